shiftreg_ctl: RTL and testbench
===============================

# shiftreg_ctl

Parametrised, length-controlled shift register for the 1-bit CPU datapath. It supports parallel load, shift direction selection, per-bit shift enable and a start/done handshake. It extends the fixed 16-bit right-shift register to any width, counts a requested number of shifts, and reports completion. Serial ALU and I/O sequencers use it to move operands in and out one bit per enabled cycle.

## Interface
- WIDTH, 16, register width in bits, minimum 2.
- CW (localparam), $clog2(WIDTH+1), width of the LEN input and the internal counter.
- CLK  in  1  rising-edge clock, the only clock.
- CLR_N  in  1  asynchronous active-low reset.
- CLR  in  1  synchronous clear, active high.
- D  in  1  serial data in.
- P  in  WIDTH  parallel load data.
- LOAD  in  1  parallel load strobe; honoured in IDLE only.
- START  in  1  start strobe; honoured in IDLE only.
- LEN  in  CW  number of shifts to perform.
- DIR  in  1  direction. 0 = right: D enters the MSB, matching the legacy block. 1 = left: D enters the LSB.
- EN  in  1  shift enable; one bit moves per cycle with EN=1 while shifting.
- Q  out  WIDTH  register contents.
- SO  out  1  serial out, the bit that the next shift discards.
- BUSY  out  1  high while in SHIFT.
- DONE  out  1  one-cycle pulse when the sequence ends.

## Operation
- State machine with three states: IDLE, SHIFT, DONE.
- IDLE, priority order CLR > LOAD > START:
  - CLR: Q <= 0.
  - LOAD: Q <= P; state stays IDLE.
  - START with LEN=0: go to DONE; Q unchanged.
  - START with LEN>0: latch DIR (and ROT, see Configuration); cnt <= min(LEN, WIDTH); go to SHIFT.
- SHIFT, on each cycle with EN=1:
  - Q shifts one place in the latched direction.
  - The inserted bit is D.
  - cnt decrements by 1.
  - When cnt=1 and EN=1, the final shift happens and the state goes to DONE.
- SHIFT, on a cycle with EN=0: Q and cnt hold.
- SHIFT ignores START and LOAD.
- CLR in any state: Q <= 0, cnt <= 0, state <= IDLE, no DONE pulse.
- DONE: lasts one cycle, then returns to IDLE. START and LOAD are ignored in this cycle.
- SO is combinational from Q and the direction register:
  - Q[0] when the direction register is 0.
  - Q[WIDTH-1] when it is 1.
- The direction register holds its last latched value while in IDLE.
- LEN values above WIDTH saturate to WIDTH.

## Timing
- Reset (CLR_N=0), asynchronous and immediate:
  - Q = 0, BUSY = 0, DONE = 0, SO = 0.
  - state = IDLE, cnt = 0, direction register = 0.
- Reset release takes effect on the first rising edge of CLK after CLR_N goes high.
- Reset in the middle of a sequence aborts it; no DONE is produced.
- START sampled at edge t:
  - BUSY is high from t to the edge of the last shift.
  - With EN held high and N = min(LEN, WIDTH), the shifts occur at edges t+1 … t+N.
  - DONE is high for exactly the cycle after edge t+N, with BUSY low in that cycle.
  - The earliest next START is at edge t+N+2.
- With LEN=0: DONE is high in the cycle after edge t; BUSY never rises.
- LOAD updates Q at the sampling edge, which is one cycle of latency.
- BUSY and DONE are registered state decodes; they are never high together.

## Configuration
- SHIFTREG_ROTATE_EN defined:
  - Adds input ROT (1 bit), latched at START.
  - When the latched ROT is 1, the inserted bit is SO (rotate) instead of D.
- SHIFTREG_ROTATE_EN undefined:
  - The ROT port is absent.
  - Behaviour is identical to ROT=0.

## Structure
- Shared package shiftreg_pkg holds:
  - the state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - the direction constants DIR_RIGHT=1'b0, DIR_LEFT=1'b1.
- One sub-module, shiftreg_cnt: a loadable down-counter with saturation on load and a terminal-count flag (cnt==1 && EN).
- The datapath and the state machine stay in shiftreg_ctl.

## Test plan
All scenarios use WIDTH=16.
- Reset during SHIFT: assert CLR_N=0 in the middle of a sequence -> Q=16'h0000, BUSY=0, DONE=0 immediately; no DONE after release.
- Right shift:
  - Stimulus: LOAD P=16'hA5C3, then START LEN=4 DIR=0 with D=1 and EN=1.
  - SO before each shift is 1, 1, 0, 0.
  - Q steps D2E1, E970, F4B8, FA5C.
  - DONE pulses in the cycle after the 4th shift.
- Left shift: LOAD 16'h0001, START LEN=20 DIR=1 D=0 -> saturates to 16 shifts; Q=16'h8000 after 15 shifts, 16'h0000 after 16; exactly one DONE pulse.
- EN gating: LEN=3 with EN alternating 1,0,1,0,1 -> Q changes only on EN cycles; BUSY lasts 5 cycles; DONE in the following cycle.
- Collisions:
  - LOAD and START in the same cycle -> load wins and the state stays IDLE.
  - START during SHIFT -> ignored.
  - LEN=0 -> DONE next cycle, Q unchanged.
  - CLR during SHIFT -> Q=0, state IDLE, no DONE.
- Rotate (SHIFTREG_ROTATE_EN defined): LOAD 16'h8001, START ROT=1 DIR=0 LEN=1 -> Q=16'hC000; with ROT=0 and D=0 -> Q=16'h4000.

Source files
------------

// File: rtl/shiftreg_pkg.sv
// Shared encodings for the length-controlled shift register and its counter.
package shiftreg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shiftreg_cnt.sv
// Loadable down-counter for the shift sequencer: saturates LEN to WIDTH on load
// and flags the terminal count when the last enabled decrement is happening.
module shiftreg_cnt #(
    parameter  int WIDTH = 16,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic [CW-1:0] len,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] MAX_CNT = CW'(WIDTH);

    logic [CW-1:0] len_sat;

    assign len_sat = (len > MAX_CNT) ? MAX_CNT : len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= len_sat;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = en && (cnt == CW'(1));

endmodule

// File: rtl/shiftreg_ctl.sv
// Length-controlled shift register with parallel load, direction select and
// start/done handshake. Define SHIFTREG_ROTATE_EN to add the ROT input.
module shiftreg_ctl
    import shiftreg_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             CLR,
    input  logic             D,
    input  logic [WIDTH-1:0] P,
    input  logic             LOAD,
    input  logic             START,
    input  logic [CW-1:0]    LEN,
    input  logic             DIR,
    input  logic             EN,
`ifdef SHIFTREG_ROTATE_EN
    input  logic             ROT,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             BUSY,
    output logic             DONE
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             dir_r;
    logic             dir_nxt;
    logic             rot_r;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_tc;
    logic [CW-1:0]    cnt;
    logic             ins_bit;

    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                   input logic             dir_sel,
                                                   input logic             ins);
        if (dir_sel == DIR_LEFT) begin
            return {v[WIDTH-2:0], ins};
        end
        return {ins, v[WIDTH-1:1]};
    endfunction

    shiftreg_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (CLK),
        .rst_n (CLR_N),
        .clr   (CLR),
        .load  (cnt_load),
        .len   (LEN),
        .en    (cnt_en),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    // Rotation feeds the outgoing bit back in at the opposite end.
    assign SO      = (dir_r == DIR_LEFT) ? Q[WIDTH-1] : Q[0];
    assign ins_bit = rot_r ? SO : D;

`ifdef SHIFTREG_ROTATE_EN
    logic rot_nxt;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            rot_r <= 1'b0;
        end else begin
            rot_r <= rot_nxt;
        end
    end
`else
    assign rot_r = 1'b0;
`endif

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state <= ST_IDLE;
            Q     <= '0;
            dir_r <= DIR_RIGHT;
        end else begin
            state <= state_nxt;
            Q     <= q_nxt;
            dir_r <= dir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        q_nxt     = Q;
        dir_nxt   = dir_r;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
`ifdef SHIFTREG_ROTATE_EN
        rot_nxt   = rot_r;
`endif
        if (CLR) begin
            state_nxt = ST_IDLE;
            q_nxt     = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (LOAD) begin
                        q_nxt = P;
                    end else if (START) begin
                        if (LEN == '0) begin
                            state_nxt = ST_DONE;
                        end else begin
                            state_nxt = ST_SHIFT;
                            dir_nxt   = DIR;
                            cnt_load  = 1'b1;
`ifdef SHIFTREG_ROTATE_EN
                            rot_nxt   = ROT;
`endif
                        end
                    end
                end
                ST_SHIFT: begin
                    if (EN) begin
                        cnt_en = 1'b1;
                        q_nxt  = shift_one(Q, dir_r, ins_bit);
                        if (cnt_tc) begin
                            state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY = (state == ST_SHIFT);
    assign DONE = (state == ST_DONE);

endmodule

// File: tb/tb_shiftreg_ctl.sv
// Scoreboard bench for shiftreg_ctl (WIDTH=16): directed scenarios, then random
// traffic checked against an arithmetic reference model.
module tb_shiftreg_ctl;

    localparam int W  = 16;
    localparam int CW = 5;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          clr    = 1'b0;
    logic          d      = 1'b0;
    logic          load   = 1'b0;
    logic          start  = 1'b0;
    logic          dir    = 1'b0;
    logic          en     = 1'b0;
    logic          rot_in = 1'b0;
    logic [W-1:0]  p      = '0;
    logic [CW-1:0] len    = '0;
    logic [W-1:0]  q;
    logic          so;
    logic          busy;
    logic          done;

    logic [W+2:0]  exp_q[$];
    logic [W-1:0]  done_q[$];
    int            vectors     = 0;
    int            miscompares = 0;

    logic [W-1:0]  mq;
    logic          mdir;
    logic          mrot;
    logic          mbusy;
    logic          mdone;
    int            mleft;

    always #5 clk = ~clk;

    shiftreg_ctl #(.WIDTH(W)) dut (
        .CLK   (clk),
        .CLR_N (rst_n),
        .CLR   (clr),
        .D     (d),
        .P     (p),
        .LOAD  (load),
        .START (start),
        .LEN   (len),
        .DIR   (dir),
        .EN    (en),
`ifdef SHIFTREG_ROTATE_EN
        .ROT   (rot_in),
`endif
        .Q     (q),
        .SO    (so),
        .BUSY  (busy),
        .DONE  (done)
    );

    function automatic logic so_of(input logic [W-1:0] v, input logic left);
        return left ? v[W-1] : v[0];
    endfunction

    function automatic logic [W+2:0] exp_tuple();
        return {mq, so_of(mq, mdir), mbusy, mdone};
    endfunction

    task automatic model_reset();
        mq = '0; mdir = 1'b0; mrot = 1'b0; mbusy = 1'b0; mdone = 1'b0; mleft = 0;
    endtask

    // One clock edge of behaviour, derived from the sequencing rules.
    task automatic model_step();
        int n;
        logic ins;
        if (!rst_n) begin
            model_reset();
        end else if (clr) begin
            mq = '0; mbusy = 1'b0; mdone = 1'b0; mleft = 0;
        end else if (mdone) begin
            mdone = 1'b0;
        end else if (mbusy) begin
            if (en) begin
                ins = mrot ? so_of(mq, mdir) : d;
                if (mdir) mq = W'((int'(mq) * 2) + int'(ins));
                else      mq = W'((int'(mq) / 2) + (ins ? 32'h8000 : 0));
                mleft--;
                if (mleft == 0) begin
                    mbusy = 1'b0;
                    mdone = 1'b1;
                    done_q.push_back(mq);
                end
            end
        end else if (load) begin
            mq = p;
        end else if (start) begin
            n = (int'(len) > W) ? W : int'(len);
            if (n == 0) begin
                mdone = 1'b1;
                done_q.push_back(mq);
            end else begin
                mbusy = 1'b1;
                mleft = n;
                mdir  = dir;
                mrot  = rot_in;
            end
        end
        exp_q.push_back(exp_tuple());
    endtask

    task automatic cyc(input logic l, input logic s, input logic e, input logic dd,
                       input logic di, input logic [W-1:0] pp, input int ln, input logic c);
        load = l; start = s; en = e; d = dd; dir = di; p = pp; len = CW'(ln); clr = c;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, expv, $time);
        end
    endtask

    // Async reset mid-cycle: outputs must clear immediately and any pending DONE is dropped.
    task automatic async_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_q", q, '0);
        chk("rst_busy", {15'd0, busy}, '0);
        chk("rst_done", {15'd0, done}, '0);
        chk("rst_so", {15'd0, so}, '0);
        exp_q.delete();
        done_q.delete();
        model_reset();
        exp_q.push_back(exp_tuple());
        idle();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        logic [W+2:0] e;
        logic [W-1:0] ev;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({q, so, busy, done} !== e) begin
                miscompares++;
                $display("FAIL trace at %0t: got q=%h so=%b busy=%b done=%b, expected q=%h so=%b busy=%b done=%b",
                         $time, q, so, busy, done, e[W+2:3], e[2], e[1], e[0]);
            end
        end
        if (done === 1'b1) begin
            vectors++;
            if (done_q.size() == 0) begin
                miscompares++;
                $display("FAIL done_event at %0t: got unexpected DONE with q=%h, expected none", $time, q);
            end else begin
                ev = done_q.pop_front();
                if (q !== ev) begin
                    miscompares++;
                    $display("FAIL done_q at %0t: got q=%h expected=%h", $time, q, ev);
                end
            end
        end
    end

    initial begin
        model_reset();
        #1;
        chk("init_q", q, '0);
        chk("init_flags", {13'd0, so, busy, done}, '0);
        idle();
        rst_n = 1'b1;
        idle();

        // Right shift of A5C3 with D=1.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 4, 1'b0);
        chk("right_so0", {15'd0, so}, 16'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 0, 1'b0);
        chk("right_q1", q, 16'hD2E1);
        chk("right_so1", {15'd0, so}, 16'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 0, 1'b0);
        chk("right_q2", q, 16'hE970);
        chk("right_so2", {15'd0, so}, 16'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 0, 1'b0);
        chk("right_q3", q, 16'hF4B8);
        chk("right_so3", {15'd0, so}, 16'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 0, 1'b0);
        chk("right_q4", q, 16'hFA5C);
        chk("right_done", {14'd0, busy, done}, 16'd1);
        idle();
        chk("right_after", {14'd0, busy, done}, 16'd0);

        // Left shift with LEN saturating to 16.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, '0, 20, 1'b0);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 0, 1'b0);
        chk("left_q15", q, 16'h8000);
        chk("left_busy15", {15'd0, busy}, 16'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 0, 1'b0);
        chk("left_q16", q, 16'h0000);
        chk("left_done", {15'd0, done}, 16'd1);
        idle();

        // EN gating: LEN=3 with EN 1,0,1,0,1.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00F0, 0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0, 3, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, (i % 2) == 0, 1'b1, 1'b0, '0, 0, 1'b0);
        chk("gate_q", q, 16'hE01E);
        chk("gate_done", {14'd0, busy, done}, 16'd1);
        idle();

        // Collisions: LOAD beats START; START during SHIFT is ignored; LEN=0.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF, 5, 1'b0);
        chk("coll_load", q, 16'hBEEF);
        chk("coll_idle", {15'd0, busy}, 16'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, '0, 4, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1111, 2, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h2222, 1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 0, 1'b0);
        chk("coll_busy", {14'd0, busy, done}, 16'd2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 0, 1'b0);
        chk("coll_q", q, 16'hEEF0);
        chk("coll_done", {14'd0, busy, done}, 16'd1);
        idle();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 0, 1'b0);
        chk("len0_done", {14'd0, busy, done}, 16'd1);
        chk("len0_q", q, 16'hEEF0);
        idle();

        // CLR during SHIFT.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 8, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 0, 1'b1);
        chk("clr_q", q, '0);
        chk("clr_flags", {14'd0, busy, done}, '0);
        idle();
        chk("clr_nodone", {15'd0, done}, '0);

        // Asynchronous reset in the middle of a sequence.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5A5A, 0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, '0, 10, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 0, 1'b0);
        async_reset();
        for (int i = 0; i < 12; i++) idle();

`ifdef SHIFTREG_ROTATE_EN
        rot_in = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8001, 0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1, 1'b0);
        rot_in = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 0, 1'b0);
        chk("rot_q", q, 16'hC000);
        idle();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8001, 0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 0, 1'b0);
        chk("norot_q", q, 16'h4000);
        idle();
`endif

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
`ifdef SHIFTREG_ROTATE_EN
            rot_in = 1'($urandom_range(0, 1));
`endif
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                int'($urandom_range(0, 31)), $urandom_range(0, 80) == 0);
            if ($urandom_range(0, 250) == 0) async_reset();
        end

        for (int i = 0; i < 20; i++) idle();
        @(negedge clk);
        #1;
        chk("pending_done", 16'(done_q.size()), 16'd0);
        chk("pending_trace", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
